writeback_arbiter: RTL and testbench
====================================

# writeback_arbiter

Merges the two producers of register results, the in-order pipeline writeback (MW stage) and the multi-cycle multiply/divide unit, into the single write port of the 32×32 register file. Pipeline results always win the port. Multdiv results are buffered in a small pending FIFO and drained into free writeback slots. A pending-hit query lets the hazard unit stall readers of not-yet-written multdiv destinations.

## Interface
Parameters:
- DATA_W, 32, register data width
- REG_W, 5, register index width
- DEPTH, 2, pending FIFO entries (power of two, ≥2)

Ports:
- clock  in  1  system clock; all state updates on rising edge
- ctrl_reset  in  1  reset, synchronous and active-high
- pipe_valid  in  1  MW-stage instruction writes a register this cycle
- pipe_reg  in  REG_W  MW-stage destination
- pipe_data  in  DATA_W  MW-stage result
- md_valid  in  1  multdiv result offered
- md_reg  in  REG_W  multdiv destination
- md_data  in  DATA_W  multdiv result
- md_ready  out  1  arbiter can accept a multdiv result; transfer = md_valid & md_ready
- chk_regA  in  REG_W  hazard query, source A
- chk_regB  in  REG_W  hazard query, source B
- chk_hit  out  1  a live pending entry targets chk_regA or chk_regB (nonzero index)
- pend_count  out  $clog2(DEPTH)+1  occupied FIFO entries
- ctrl_writeEnable  out  1  register-file write enable
- ctrl_writeReg  out  REG_W  register-file write index
- data_writeReg  out  DATA_W  register-file write data

## Operation
- Pipe slot busy = pipe_valid & (pipe_reg != 0). Writes to $0 are never issued; pipe_valid with pipe_reg = 0 counts as an idle slot.
- Port select, combinational, by priority:
  1. Pipe slot busy: write pipe_reg/pipe_data.
  2. Else the FIFO head is live: write the head and pop it.
  3. Else the FIFO is empty and a transfer occurs with md_reg != 0: write-through md_reg/md_data. Nothing is enqueued.
  4. Else ctrl_writeEnable = 0.
- Enqueue: on a transfer not consumed by write-through and with md_reg != 0, push {live=1, reg, data} at the tail. A transfer with md_reg = 0 is accepted and dropped.
- WAW kill: when the pipe slot is busy, every live FIFO entry with reg == pipe_reg is marked dead at the clock edge. A same-cycle transfer with md_reg == pipe_reg is accepted and dropped, because the pipe result is younger.
- A dead head pops every cycle without writing, regardless of pipe activity.
- md_ready = !ctrl_reset & (pend_count < DEPTH). It depends only on registered count; a same-cycle pop does not raise it.
- chk_hit is combinational over live entries only. It also includes an in-flight enqueue this cycle with matching reg.
- ctrl_writeReg/data_writeReg are 0 whenever ctrl_writeEnable = 0.

## Timing
- Reset: FIFO empty, all entries dead, pend_count = 0, md_ready = 0, chk_hit = 0, ctrl_writeEnable = 0. Reset mid-operation discards all pending results.
- Latency md→regfile: 0 cycles on write-through. Otherwise, N busy pipe cycles after enqueue, the entry writes on the first cycle with a free slot once it is at the head.
- Push and pop in the same cycle: count unchanged, pointers wrap modulo DEPTH.
- Full FIFO with a pop: md_ready still 0 that cycle and 1 the next.
- Kill and pop of the same entry in the same cycle: the pop wins and the head is written only if the pipe slot is free. Under the priority rules that case cannot occur, so the kill is a no-op.

## Structure
- Shared package writeback_pkg: DATA_W, REG_W, REG_ZERO = 0, typedef wb_entry_t {live, reg, data}.
- Sub-module wb_pending_fifo: circular buffer of wb_entry_t with push, pop, per-entry kill-by-reg, match-query ports, and count.
- The top level holds only the priority mux and handshake.

## Test plan
- Idle pipe, empty FIFO, md_valid with reg 5, data 0xDEADBEEF → same-cycle write-enable to r5 with 0xDEADBEEF; pend_count stays 0.
- Pipe busy writing r3 for 3 cycles while md sends r7 = 0x11 → pend_count 1, chk_hit = 1 for chk_regA = 7. The r7 write occurs in cycle 4 and pend_count returns to 0.
- Pipe busy continuously and two md transfers (r8, r9) → md_ready drops to 0. A third md_valid is held. When the pipe goes idle, r8 then r9 write on consecutive cycles and md_ready returns one cycle after the first pop.
- r10 = 0x22 pending, then the pipe writes r10 = 0x33 → the pipe write occurs, the entry is killed, and no later write to r10 happens. chk_hit for r10 is 0 after the edge.
- md transfer to r0, and the pipe writing r0 → ctrl_writeEnable stays 0 and pend_count stays 0.
- Assert ctrl_reset with 2 entries pending → the next cycle shows pend_count 0, md_ready 0 during reset and 1 after, and no pending writes ever appear.

Source files
------------

// File: rtl/writeback_arbiter_pkg.sv
// rtl/writeback_arbiter_pkg.sv - shared widths and pending-entry type for the writeback arbiter
//
// Purpose: register data/index widths, the $0 index and the pending FIFO entry
//          record shared by the arbiter top, its interface and its FIFO.
// Ports:   none (package).
package writeback_pkg;

   localparam int DATA_W = 32;
   localparam int REG_W  = 5;

   localparam logic [REG_W-1:0] REG_ZERO = '0;

   // dst holds the destination register index; live clears on kill or pop.
   typedef struct packed {
      logic              live;
      logic [REG_W-1:0]  dst;
      logic [DATA_W-1:0] data;
   } wb_entry_t;

endpackage

// File: rtl/writeback_arbiter_if.sv
// rtl/writeback_arbiter_if.sv - producer, hazard-query and register-file port bundle
//
// Purpose: groups the pipe/multdiv producers, the hazard query and the
//          register-file write port of writeback_arbiter.
// Ports:   master - drives pipe_*, md_valid/md_reg/md_data, chk_regA/B;
//                   observes md_ready, chk_hit, pend_count and the write port.
//          slave  - the arbiter side (directions reversed).
interface writeback_arbiter_if #(
   parameter int DATA_W = writeback_pkg::DATA_W,
   parameter int REG_W  = writeback_pkg::REG_W,
   parameter int DEPTH  = 2
);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic              pipe_valid;
   logic [REG_W-1:0]  pipe_reg;
   logic [DATA_W-1:0] pipe_data;
   logic              md_valid;
   logic [REG_W-1:0]  md_reg;
   logic [DATA_W-1:0] md_data;
   logic              md_ready;
   logic [REG_W-1:0]  chk_regA;
   logic [REG_W-1:0]  chk_regB;
   logic              chk_hit;
   logic [CNT_W-1:0]  pend_count;
   logic              ctrl_writeEnable;
   logic [REG_W-1:0]  ctrl_writeReg;
   logic [DATA_W-1:0] data_writeReg;

   modport master (
      output pipe_valid, pipe_reg, pipe_data,
      output md_valid, md_reg, md_data,
      output chk_regA, chk_regB,
      input  md_ready, chk_hit, pend_count,
      input  ctrl_writeEnable, ctrl_writeReg, data_writeReg
   );

   modport slave (
      input  pipe_valid, pipe_reg, pipe_data,
      input  md_valid, md_reg, md_data,
      input  chk_regA, chk_regB,
      output md_ready, chk_hit, pend_count,
      output ctrl_writeEnable, ctrl_writeReg, data_writeReg
   );

endinterface

// File: rtl/writeback_arbiter_pending_fifo.sv
// rtl/writeback_arbiter_pending_fifo.sv - circular buffer of multdiv results awaiting a write slot
//
// Purpose: holds wb_entry_t records in arrival order, supports push, pop,
//          kill-by-register of every live entry, and two match queries.
// Ports:   clock, ctrl_reset   - clock, synchronous active-high reset
//          push, push_entry    - append an entry at the tail
//          pop                 - retire the head (caller pops only when count != 0)
//          kill_en, kill_reg   - mark dead every live entry targeting kill_reg
//          query_a, query_b    - register indices to match against live entries
//          head                - head entry, all-zero when empty
//          count               - occupied entries, live or dead
//          hit_a, hit_b        - a live entry targets query_a / query_b (nonzero)
module wb_pending_fifo
   import writeback_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                     clock,
   input  logic                     ctrl_reset,
   input  logic                     push,
   input  wb_entry_t                push_entry,
   input  logic                     pop,
   input  logic                     kill_en,
   input  logic [REG_W-1:0]         kill_reg,
   input  logic [REG_W-1:0]         query_a,
   input  logic [REG_W-1:0]         query_b,
   output wb_entry_t                head,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     hit_a,
   output logic                     hit_b
);
   localparam int PTR_W = $clog2(DEPTH);

   wb_entry_t        mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;

   assign head = (count != '0) ? mem[rd_ptr] : '0;

   // Unoccupied slots always have live = 0 (cleared on pop), so scanning
   // every slot is equivalent to scanning only the occupied range.
   always_comb begin
      hit_a = 1'b0;
      hit_b = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (mem[i].live && mem[i].dst == query_a && query_a != REG_ZERO) hit_a = 1'b1;
         if (mem[i].live && mem[i].dst == query_b && query_b != REG_ZERO) hit_b = 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (ctrl_reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (kill_en) begin
            for (int i = 0; i < DEPTH; i++) begin
               if (mem[i].live && mem[i].dst == kill_reg) mem[i].live <= 1'b0;
            end
         end
         // Pointers are PTR_W bits wide, so increments wrap modulo DEPTH.
         if (push) begin
            mem[wr_ptr] <= push_entry;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) begin
            mem[rd_ptr].live <= 1'b0;
            rd_ptr           <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/writeback_arbiter.sv
// rtl/writeback_arbiter.sv - merges pipeline and multdiv results onto the register-file write port
//
// Purpose: pipeline results always own the write port; multdiv results are
//          written through when possible, otherwise queued in wb_pending_fifo
//          and drained into idle writeback slots. Answers hazard queries.
// Ports:   clock, ctrl_reset - clock, synchronous active-high reset
//          bus (slave)       - pipe_*, md_* handshake, chk_* query, pend_count,
//                              ctrl_writeEnable/ctrl_writeReg/data_writeReg
module writeback_arbiter
   import writeback_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                clock,
   input  logic                ctrl_reset,
   writeback_arbiter_if.slave  bus
);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   wb_entry_t         head;
   wb_entry_t         push_entry;
   logic [CNT_W-1:0]  count;
   logic              hit_a;
   logic              hit_b;
   logic              pipe_busy;
   logic              md_ready;
   logic              xfer;
   logic              fifo_empty;
   logic              head_dead;
   logic              write_through;
   logic              push;
   logic              pop;
   logic              we;
   logic [REG_W-1:0]  wr_reg;
   logic [DATA_W-1:0] wr_data;

   assign pipe_busy  = bus.pipe_valid && bus.pipe_reg != REG_ZERO;
   assign fifo_empty = count == '0;
   assign head_dead  = !fifo_empty && !head.live;
   // Uses the registered count only: a pop this cycle does not reopen the port.
   assign md_ready   = !ctrl_reset && count < CNT_W'(DEPTH);
   assign xfer       = bus.md_valid && md_ready;

   always_comb begin
      write_through = 1'b0;
      pop           = 1'b0;
      we            = 1'b0;
      wr_reg        = '0;
      wr_data       = '0;
      if (!ctrl_reset) begin
         if (pipe_busy) begin
            we      = 1'b1;
            wr_reg  = bus.pipe_reg;
            wr_data = bus.pipe_data;
         end else if (head.live) begin
            we      = 1'b1;
            wr_reg  = head.dst;
            wr_data = head.data;
            pop     = 1'b1;
         end else if (fifo_empty && xfer && bus.md_reg != REG_ZERO) begin
            we            = 1'b1;
            wr_reg        = bus.md_reg;
            wr_data       = bus.md_data;
            write_through = 1'b1;
         end
         // Dead heads drain silently even while the pipe owns the port.
         if (head_dead) pop = 1'b1;
      end
   end

   // A transfer whose destination matches the busy pipe slot is older than
   // the pipe result, so it is accepted and discarded.
   assign push = xfer && bus.md_reg != REG_ZERO && !write_through &&
                 !(pipe_busy && bus.md_reg == bus.pipe_reg);

   assign push_entry = '{live: 1'b1, dst: bus.md_reg, data: bus.md_data};

   wb_pending_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clock      (clock),
      .ctrl_reset (ctrl_reset),
      .push       (push),
      .push_entry (push_entry),
      .pop        (pop),
      .kill_en    (pipe_busy),
      .kill_reg   (bus.pipe_reg),
      .query_a    (bus.chk_regA),
      .query_b    (bus.chk_regB),
      .head       (head),
      .count      (count),
      .hit_a      (hit_a),
      .hit_b      (hit_b)
   );

   assign bus.md_ready         = md_ready;
   assign bus.pend_count       = count;
   assign bus.chk_hit          = !ctrl_reset && (hit_a || hit_b ||
                                 (push && (bus.md_reg == bus.chk_regA || bus.md_reg == bus.chk_regB)));
   assign bus.ctrl_writeEnable = we;
   assign bus.ctrl_writeReg    = wr_reg;
   assign bus.data_writeReg    = wr_data;

endmodule

// File: tb/tb_writeback_arbiter.sv
// tb/tb_writeback_arbiter.sv - directed self-checking bench for writeback_arbiter
module tb_writeback_arbiter;

   logic clock = 1'b0;
   logic ctrl_reset;
   int   checks = 0;
   int   errors = 0;

   always #5 clock = ~clock;

   writeback_arbiter_if #(.DATA_W(32), .REG_W(5), .DEPTH(2)) bus ();

   writeback_arbiter #(.DEPTH(2)) dut (
      .clock      (clock),
      .ctrl_reset (ctrl_reset),
      .bus        (bus)
   );

   // Advance past the next rising edge; inputs are then changed and outputs sampled mid-cycle.
   task automatic next_cycle();
      @(posedge clock);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic idle_inputs();
      bus.pipe_valid = 1'b0; bus.pipe_reg = '0; bus.pipe_data = '0;
      bus.md_valid   = 1'b0; bus.md_reg   = '0; bus.md_data   = '0;
      bus.chk_regA   = '0;   bus.chk_regB = '0;
   endtask

   task automatic test_reset();
      ctrl_reset = 1'b1;
      idle_inputs();
      next_cycle();
      next_cycle();
      settle();
      checks++; if (bus.pend_count !== 2'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", bus.pend_count); end
      checks++; if (bus.md_ready !== 1'b0) begin errors++; $display("FAIL rst_md_ready got %0b exp 0", bus.md_ready); end
      checks++; if (bus.chk_hit !== 1'b0) begin errors++; $display("FAIL rst_chk_hit got %0b exp 0", bus.chk_hit); end
      checks++; if (bus.ctrl_writeEnable !== 1'b0) begin errors++; $display("FAIL rst_we got %0b exp 0", bus.ctrl_writeEnable); end
      ctrl_reset = 1'b0;
      next_cycle();
   endtask

   task automatic test_write_through();
      bus.md_valid = 1'b1; bus.md_reg = 5'd5; bus.md_data = 32'hDEADBEEF;
      settle();
      checks++; if (bus.md_ready !== 1'b1) begin errors++; $display("FAIL wt_ready got %0b exp 1", bus.md_ready); end
      checks++; if (bus.ctrl_writeEnable !== 1'b1) begin errors++; $display("FAIL wt_we got %0b exp 1", bus.ctrl_writeEnable); end
      checks++; if (bus.ctrl_writeReg !== 5'd5) begin errors++; $display("FAIL wt_reg got %0d exp 5", bus.ctrl_writeReg); end
      checks++; if (bus.data_writeReg !== 32'hDEADBEEF) begin errors++; $display("FAIL wt_data got %0h exp deadbeef", bus.data_writeReg); end
      next_cycle();
      idle_inputs();
      settle();
      checks++; if (bus.pend_count !== 2'd0) begin errors++; $display("FAIL wt_count got %0d exp 0", bus.pend_count); end
      checks++; if (bus.ctrl_writeEnable !== 1'b0) begin errors++; $display("FAIL wt_idle_we got %0b exp 0", bus.ctrl_writeEnable); end
      checks++; if (bus.ctrl_writeReg !== 5'd0 || bus.data_writeReg !== 32'd0) begin errors++; $display("FAIL wt_idle_zero got reg %0d data %0h exp 0 0", bus.ctrl_writeReg, bus.data_writeReg); end
   endtask

   task automatic test_queue_behind_pipe();
      // cycle 1: pipe writes r3, multdiv offers r7 which must queue
      bus.pipe_valid = 1'b1; bus.pipe_reg = 5'd3; bus.pipe_data = 32'hA;
      bus.md_valid = 1'b1; bus.md_reg = 5'd7; bus.md_data = 32'h11;
      bus.chk_regA = 5'd7;
      settle();
      checks++; if (bus.ctrl_writeReg !== 5'd3 || bus.data_writeReg !== 32'hA) begin errors++; $display("FAIL q_c1_port got reg %0d data %0h exp 3 a", bus.ctrl_writeReg, bus.data_writeReg); end
      checks++; if (bus.chk_hit !== 1'b1) begin errors++; $display("FAIL q_c1_inflight_hit got %0b exp 1", bus.chk_hit); end
      next_cycle();
      bus.md_valid = 1'b0;
      for (int c = 2; c <= 3; c++) begin
         settle();
         checks++; if (bus.pend_count !== 2'd1) begin errors++; $display("FAIL q_c%0d_count got %0d exp 1", c, bus.pend_count); end
         checks++; if (bus.chk_hit !== 1'b1) begin errors++; $display("FAIL q_c%0d_hit got %0b exp 1", c, bus.chk_hit); end
         checks++; if (bus.ctrl_writeReg !== 5'd3) begin errors++; $display("FAIL q_c%0d_reg got %0d exp 3", c, bus.ctrl_writeReg); end
         next_cycle();
      end
      // cycle 4: pipe idle, queued r7 drains
      bus.pipe_valid = 1'b0;
      settle();
      checks++; if (bus.ctrl_writeEnable !== 1'b1 || bus.ctrl_writeReg !== 5'd7 || bus.data_writeReg !== 32'h11) begin errors++; $display("FAIL q_c4_drain got we %0b reg %0d data %0h exp 1 7 11", bus.ctrl_writeEnable, bus.ctrl_writeReg, bus.data_writeReg); end
      next_cycle();
      settle();
      checks++; if (bus.pend_count !== 2'd0) begin errors++; $display("FAIL q_after_count got %0d exp 0", bus.pend_count); end
      checks++; if (bus.chk_hit !== 1'b0) begin errors++; $display("FAIL q_after_hit got %0b exp 0", bus.chk_hit); end
      idle_inputs();
   endtask

   task automatic test_back_to_back();
      bus.pipe_valid = 1'b1; bus.pipe_reg = 5'd1; bus.pipe_data = 32'h1;
      bus.md_valid = 1'b1; bus.md_reg = 5'd8; bus.md_data = 32'h88;
      settle();
      checks++; if (bus.md_ready !== 1'b1) begin errors++; $display("FAIL bb_c1_ready got %0b exp 1", bus.md_ready); end
      next_cycle();
      bus.md_reg = 5'd9; bus.md_data = 32'h99;
      settle();
      checks++; if (bus.md_ready !== 1'b1 || bus.pend_count !== 2'd1) begin errors++; $display("FAIL bb_c2 got ready %0b count %0d exp 1 1", bus.md_ready, bus.pend_count); end
      next_cycle();
      bus.md_reg = 5'd10; bus.md_data = 32'hAA;
      settle();
      checks++; if (bus.md_ready !== 1'b0 || bus.pend_count !== 2'd2) begin errors++; $display("FAIL bb_full got ready %0b count %0d exp 0 2", bus.md_ready, bus.pend_count); end
      next_cycle();
      settle();
      checks++; if (bus.pend_count !== 2'd2) begin errors++; $display("FAIL bb_held_count got %0d exp 2", bus.pend_count); end
      next_cycle();
      // pipe idle: r8 pops but md_ready stays low this cycle
      bus.pipe_valid = 1'b0;
      settle();
      checks++; if (bus.ctrl_writeReg !== 5'd8 || bus.data_writeReg !== 32'h88) begin errors++; $display("FAIL bb_pop8 got reg %0d data %0h exp 8 88", bus.ctrl_writeReg, bus.data_writeReg); end
      checks++; if (bus.md_ready !== 1'b0) begin errors++; $display("FAIL bb_pop_ready got %0b exp 0", bus.md_ready); end
      next_cycle();
      settle();
      checks++; if (bus.ctrl_writeReg !== 5'd9 || bus.data_writeReg !== 32'h99) begin errors++; $display("FAIL bb_pop9 got reg %0d data %0h exp 9 99", bus.ctrl_writeReg, bus.data_writeReg); end
      checks++; if (bus.md_ready !== 1'b1 || bus.pend_count !== 2'd1) begin errors++; $display("FAIL bb_reopen got ready %0b count %0d exp 1 1", bus.md_ready, bus.pend_count); end
      next_cycle();
      bus.md_valid = 1'b0;
      settle();
      checks++; if (bus.pend_count !== 2'd1 || bus.ctrl_writeReg !== 5'd10 || bus.data_writeReg !== 32'hAA) begin errors++; $display("FAIL bb_pop10 got count %0d reg %0d data %0h exp 1 10 aa", bus.pend_count, bus.ctrl_writeReg, bus.data_writeReg); end
      next_cycle();
      settle();
      checks++; if (bus.pend_count !== 2'd0 || bus.ctrl_writeEnable !== 1'b0) begin errors++; $display("FAIL bb_empty got count %0d we %0b exp 0 0", bus.pend_count, bus.ctrl_writeEnable); end
      idle_inputs();
   endtask

   task automatic test_waw_kill();
      bus.pipe_valid = 1'b1; bus.pipe_reg = 5'd1; bus.pipe_data = 32'h1;
      bus.md_valid = 1'b1; bus.md_reg = 5'd10; bus.md_data = 32'h22;
      next_cycle();
      bus.md_valid = 1'b0;
      bus.pipe_reg = 5'd10; bus.pipe_data = 32'h33;
      bus.chk_regB = 5'd10;
      settle();
      checks++; if (bus.ctrl_writeReg !== 5'd10 || bus.data_writeReg !== 32'h33) begin errors++; $display("FAIL waw_pipe got reg %0d data %0h exp 10 33", bus.ctrl_writeReg, bus.data_writeReg); end
      checks++; if (bus.chk_hit !== 1'b1) begin errors++; $display("FAIL waw_pre_hit got %0b exp 1", bus.chk_hit); end
      next_cycle();
      bus.pipe_valid = 1'b0;
      settle();
      checks++; if (bus.chk_hit !== 1'b0) begin errors++; $display("FAIL waw_post_hit got %0b exp 0", bus.chk_hit); end
      checks++; if (bus.ctrl_writeEnable !== 1'b0) begin errors++; $display("FAIL waw_dead_we got %0b exp 0", bus.ctrl_writeEnable); end
      next_cycle();
      settle();
      checks++; if (bus.pend_count !== 2'd0 || bus.ctrl_writeEnable !== 1'b0) begin errors++; $display("FAIL waw_drained got count %0d we %0b exp 0 0", bus.pend_count, bus.ctrl_writeEnable); end
      // same-cycle transfer to the pipe destination is accepted and dropped
      bus.pipe_valid = 1'b1; bus.pipe_reg = 5'd12; bus.pipe_data = 32'h5;
      bus.md_valid = 1'b1; bus.md_reg = 5'd12; bus.md_data = 32'h6;
      settle();
      checks++; if (bus.md_ready !== 1'b1 || bus.data_writeReg !== 32'h5) begin errors++; $display("FAIL waw_same got ready %0b data %0h exp 1 5", bus.md_ready, bus.data_writeReg); end
      next_cycle();
      idle_inputs();
      settle();
      checks++; if (bus.pend_count !== 2'd0 || bus.ctrl_writeEnable !== 1'b0) begin errors++; $display("FAIL waw_same_drop got count %0d we %0b exp 0 0", bus.pend_count, bus.ctrl_writeEnable); end
   endtask

   task automatic test_reg_zero();
      bus.pipe_valid = 1'b1; bus.pipe_reg = 5'd0; bus.pipe_data = 32'h5;
      bus.md_valid = 1'b1; bus.md_reg = 5'd0; bus.md_data = 32'h7;
      settle();
      checks++; if (bus.ctrl_writeEnable !== 1'b0 || bus.md_ready !== 1'b1) begin errors++; $display("FAIL zero_we got we %0b ready %0b exp 0 1", bus.ctrl_writeEnable, bus.md_ready); end
      next_cycle();
      idle_inputs();
      settle();
      checks++; if (bus.pend_count !== 2'd0) begin errors++; $display("FAIL zero_count got %0d exp 0", bus.pend_count); end
   endtask

   task automatic test_reset_midway();
      bus.pipe_valid = 1'b1; bus.pipe_reg = 5'd1; bus.pipe_data = 32'h1;
      bus.md_valid = 1'b1; bus.md_reg = 5'd4; bus.md_data = 32'h44;
      next_cycle();
      bus.md_reg = 5'd6; bus.md_data = 32'h66;
      next_cycle();
      idle_inputs();
      settle();
      checks++; if (bus.pend_count !== 2'd2) begin errors++; $display("FAIL mr_filled got %0d exp 2", bus.pend_count); end
      ctrl_reset = 1'b1;
      settle();
      checks++; if (bus.md_ready !== 1'b0 || bus.ctrl_writeEnable !== 1'b0) begin errors++; $display("FAIL mr_in_reset got ready %0b we %0b exp 0 0", bus.md_ready, bus.ctrl_writeEnable); end
      next_cycle();
      settle();
      checks++; if (bus.pend_count !== 2'd0 || bus.md_ready !== 1'b0) begin errors++; $display("FAIL mr_cleared got count %0d ready %0b exp 0 0", bus.pend_count, bus.md_ready); end
      ctrl_reset = 1'b0;
      settle();
      checks++; if (bus.md_ready !== 1'b1) begin errors++; $display("FAIL mr_ready_after got %0b exp 1", bus.md_ready); end
      for (int c = 0; c < 3; c++) begin
         checks++; if (bus.ctrl_writeEnable !== 1'b0) begin errors++; $display("FAIL mr_no_write_%0d got we %0b reg %0d exp 0", c, bus.ctrl_writeEnable, bus.ctrl_writeReg); end
         next_cycle();
         settle();
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_write_through();
      test_queue_behind_pipe();
      test_back_to_back();
      test_waw_kill();
      test_reg_zero();
      test_reset_midway();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
